// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory-port model.
// The MEM_RESPONDER_TICK_EN build option maps a tick counter at TICK_ADDR.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [31:0] TICK_ADDR       = 32'h4000_0014;
  localparam int          MAX_WAIT_CYCLES = 15;
  localparam int          CNT_W           = $clog2(MAX_WAIT_CYCLES + 1);

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word RAM: one write or read per cycle, registered read data.
// Contents are deliberately not reset.
module mem_responder_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             we_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with WAIT_CYCLES wait states and a one-cycle Ready pulse.
// Build option MEM_RESPONDER_TICK_EN adds a free-running tick counter at TICK_ADDR.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Mem_data,
  output logic        Ready,
  output logic        Err
);

  localparam int   IDX_W     = $clog2(DEPTH_WORDS);
  localparam cnt_t WAIT_INIT = cnt_t'(WAIT_CYCLES);

  state_e      state_q;
  cnt_t        cnt_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        is_write_q;
  logic        conflict_q;
  logic        resp_err_q;
  logic        resp_zero_q;
  logic [31:0] mem_data_q;
  logic        ready_q;
  logic        err_q;

  logic [29:0]      word_off;
  logic             in_range;
  logic             tick_hit;
  logic             ram_we;
  logic [31:0]      ram_rdata;
  logic [31:0]      rd_value;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^Address[1:0];

  // Word offset is computed modulo 2^30; an address below BASE_ADDR wraps high and fails the compare.
  assign word_off = addr_q - BASE_ADDR[31:2];
  assign in_range = (word_off < 30'(DEPTH_WORDS));
  assign ram_we   = (state_q == ST_ACCESS) && is_write_q && in_range && !tick_hit;

  mem_responder_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk    (clk),
    .idx_i  (word_off[IDX_W-1:0]),
    .we_i   (ram_we),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

`ifdef MEM_RESPONDER_TICK_EN
  logic [31:0] tick_q;
  logic [31:0] tick_smp_q;
  logic        resp_tick_q;

  assign tick_hit = (addr_q == TICK_ADDR[31:2]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q      <= '0;
      tick_smp_q  <= '0;
      resp_tick_q <= 1'b0;
    end else begin
      if ((state_q == ST_ACCESS) && tick_hit && is_write_q) begin
        tick_q <= wdata_q;
      end else begin
        tick_q <= tick_q + 32'd1;
      end
      if (state_q == ST_ACCESS) begin
        resp_tick_q <= tick_hit && !is_write_q;
        tick_smp_q  <= tick_q;
      end
    end
  end

  always_comb begin
    rd_value = ram_rdata;
    if (resp_zero_q) begin
      rd_value = '0;
    end
    if (resp_tick_q) begin
      rd_value = tick_smp_q;
    end
  end
`else
  assign tick_hit = 1'b0;

  always_comb begin
    rd_value = ram_rdata;
    if (resp_zero_q) begin
      rd_value = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      conflict_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_zero_q <= 1'b0;
      mem_data_q  <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (MemRead || MemWrite) begin
            addr_q     <= Address[31:2];
            wdata_q    <= Write_data;
            is_write_q <= MemWrite;
            conflict_q <= MemRead && MemWrite;
            cnt_q      <= WAIT_INIT;
            state_q    <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - cnt_t'(1);
          if (cnt_q <= cnt_t'(1)) begin
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          resp_err_q  <= conflict_q || !(in_range || tick_hit);
          resp_zero_q <= !in_range && !tick_hit;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          ready_q <= 1'b1;
          err_q   <= resp_err_q;
          if (!is_write_q) begin
            mem_data_q <= rd_value;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Mem_data = mem_data_q;
  assign Ready    = ready_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES=2 and 0) with a queue-based scoreboard.
// Build with MEM_RESPONDER_TICK_EN defined to exercise the tick counter expectations.
module tb_mem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] TICK  = 32'h4000_0014;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    logic        upd;
    logic        known;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n  [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        mread  [2];
  logic        mwrite [2];
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, err0, err1;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .Address(addr[0]), .Write_data(wdata[0]),
    .MemRead(mread[0]), .MemWrite(mwrite[0]),
    .Mem_data(rdata0), .Ready(ready0), .Err(err0)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .Address(addr[1]), .Write_data(wdata[1]),
    .MemRead(mread[1]), .MemWrite(mwrite[1]),
    .Mem_data(rdata1), .Ready(ready1), .Err(err1)
  );

  // scoreboard state
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  logic [31:0] model [2][DEPTH];
  logic [31:0] hold [2];
  logic        hold_known [2];
  int          last_rdy [2];

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    if ($isunknown(act) || act < lo || act > hi) begin
      failures++;
      if (lo == hi) $display("FAIL %s: got %h, want %h", name, act, lo);
      else          $display("FAIL %s: got %h, want %h..%h", name, act, lo, hi);
    end
  endtask

  task automatic push_exp(input int d, input exp_t x);
    if (d == 0) exp_q0.push_back(x);
    else        exp_q1.push_back(x);
  endtask

  // Reference model: address decode from the byte address, RAM as a plain array.
  function automatic exp_t predict(input int d, input bit rd, input bit wr,
                                   input logic [31:0] a, input logic [31:0] wd);
    exp_t        x;
    logic [31:0] word;
    bit          inr;
    word    = (a - BASE) >> 2;
    inr     = (word < DEPTH);
    x.lo    = 32'h0;
    x.known = 1'b1;
    if (wr) begin
      x.err = rd || !inr;
      x.upd = 1'b0;
      if (inr) model[d][int'(word)] = wd;
    end else begin
      x.err = !inr;
      x.upd = 1'b1;
      if (inr) x.lo = model[d][int'(word)];
    end
    x.hi = x.lo;
    return x;
  endfunction

  // monitor
  task automatic monitor_inst(input int d);
    logic        r, e;
    logic [31:0] m;
    exp_t        x;
    bit          have;
    r = (d == 0) ? ready0 : ready1;
    e = (d == 0) ? err0   : err1;
    m = (d == 0) ? rdata0 : rdata1;
    if (r) begin
      have = 1'b0;
      if (d == 0 && exp_q0.size() > 0) begin x = exp_q0.pop_front(); have = 1'b1; end
      if (d == 1 && exp_q1.size() > 0) begin x = exp_q1.pop_front(); have = 1'b1; end
      if (!have) begin
        chk($sformatf("u%0d_unexpected_ready", d), {31'b0, r}, 32'h0, 32'h0);
      end else begin
        chk($sformatf("u%0d_err", d), {31'b0, e}, {31'b0, x.err}, {31'b0, x.err});
        if (x.upd) begin
          chk($sformatf("u%0d_rdata", d), m, x.lo, x.hi);
          hold[d]       = x.lo;
          hold_known[d] = x.known;
        end else if (hold_known[d]) begin
          chk($sformatf("u%0d_data_held_on_write", d), m, hold[d], hold[d]);
        end
      end
    end else begin
      chk($sformatf("u%0d_err_idle", d), {31'b0, e}, 32'h0, 32'h0);
      if (hold_known[d]) chk($sformatf("u%0d_data_held", d), m, hold[d], hold[d]);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d]) monitor_inst(d);
    end
  end

  // driver tasks: called #1 after a rising edge, return #1 after the Ready edge
  task automatic req(input int d, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] wd, input exp_t x);
    int   k;
    logic r;
    addr[d]   = a;
    wdata[d]  = wd;
    mread[d]  = rd;
    mwrite[d] = wr;
    push_exp(d, x);
    @(posedge clk); #1;
    k = 0;
    r = (d == 0) ? ready0 : ready1;
    while (!r && k < 40) begin
      @(posedge clk); #1;
      k++;
      r = (d == 0) ? ready0 : ready1;
    end
    chk($sformatf("u%0d_latency", d), k, wait_of(d) + 2, wait_of(d) + 2);
    last_rdy[d] = cyc;
  endtask

  task automatic op(input int d, input bit rd, input bit wr,
                    input logic [31:0] a, input logic [31:0] wd);
    req(d, rd, wr, a, wd, predict(d, rd, wr, a, wd));
  endtask

  task automatic idle(input int d, input int n);
    mread[d]  = 1'b0;
    mwrite[d] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r0;
    int          cw;
    int          v;
    exp_t        x;
    logic [31:0] old_word;
    for (int d = 0; d < 2; d++) begin
      rst_n[d]      = 1'b0;
      addr[d]       = '0;
      wdata[d]      = '0;
      mread[d]      = 1'b0;
      mwrite[d]     = 1'b0;
      hold[d]       = '0;
      hold_known[d] = 1'b1;
      last_rdy[d]   = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    chk("u0_reset_ready", {31'b0, ready0}, 32'h0, 32'h0);
    chk("u0_reset_err",   {31'b0, err0},   32'h0, 32'h0);
    chk("u0_reset_data",  rdata0,          32'h0, 32'h0);
    chk("u1_reset_ready", {31'b0, ready1}, 32'h0, 32'h0);
    chk("u1_reset_data",  rdata1,          32'h0, 32'h0);

    // known contents for words 0..15 of both instances
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) op(d, 1'b0, 1'b1, 32'(w * 4), $urandom);
      idle(d, 1);
    end

    // write then read with ignored byte-offset bits
    op(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    op(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0);
    idle(0, 1);

    // zero wait states: back-to-back reads every third cycle
    op(1, 1'b1, 1'b0, 32'h0, 32'h0);
    r0 = last_rdy[1];
    op(1, 1'b1, 1'b0, 32'h4, 32'h0);
    chk("u1_b2b_spacing", last_rdy[1] - r0, 32'd3, 32'd3);
    for (int i = 0; i < 6; i++) begin
      r0 = last_rdy[1];
      op(1, 1'b1, 1'b0, 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)), 32'h0);
      chk("u1_b2b_spacing", last_rdy[1] - r0, 32'd3, 32'd3);
    end
    idle(1, 2);

    // out of range read/write, then confirm no in-range word changed
    op(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
    op(0, 1'b0, 1'b1, 32'h0000_0400, 32'hBAD0_0400);
    op(0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hBAD0_FFFC);
    idle(0, 1);
    for (int w = 0; w < 16; w++) op(0, 1'b1, 1'b0, 32'(w * 4), 32'h0);
    idle(0, 1);

    // conflicting request executes as a write with Err
    op(0, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678);
    op(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    idle(0, 1);

    // reset during WAIT aborts a pending write
    old_word  = model[0][8];
    addr[0]   = 32'h0000_0020;
    wdata[0]  = ~old_word;
    mwrite[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("u0_abort_ready", {31'b0, ready0}, 32'h0, 32'h0);
    chk("u0_abort_err",   {31'b0, err0},   32'h0, 32'h0);
    chk("u0_abort_data",  rdata0,          32'h0, 32'h0);
    mwrite[0] = 1'b0;
    hold[0]   = 32'h0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    op(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    idle(0, 1);

    // tick counter address
`ifdef MEM_RESPONDER_TICK_EN
    x.lo = 32'h0; x.hi = 32'h0; x.err = 1'b0; x.upd = 1'b0; x.known = 1'b1;
    req(0, 1'b0, 1'b1, TICK, 32'h0, x);
    cw = last_rdy[0];
    idle(0, 10);
    v = (cyc + 1 + wait_of(0) + 2) - cw - 1;
    x.lo = 32'(v - 1); x.hi = 32'(v + 1); x.err = 1'b0; x.upd = 1'b1; x.known = 1'b0;
    req(0, 1'b1, 1'b0, TICK, 32'h0, x);
`else
    op(0, 1'b0, 1'b1, TICK, 32'h0);
    cw = last_rdy[0];
    idle(0, 10);
    v = cw;
    op(0, 1'b1, 1'b0, TICK, 32'h0);
`endif
    idle(0, 1);

    // randomized mix across both instances
    for (int i = 0; i < 60; i++) begin
      int          d;
      int          kind;
      logic [31:0] a;
      logic [31:0] oor;
      d    = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      oor  = ($urandom_range(0, 1) == 0) ? 32'(32'h400 + $urandom_range(0, 255) * 4)
                                         : 32'hF000_0000 + 32'($urandom_range(0, 63) * 4);
      case (kind)
        0, 1, 2, 3: op(d, 1'b1, 1'b0, a, 32'h0);
        4, 5, 6:    op(d, 1'b0, 1'b1, a, $urandom);
        7:          op(d, 1'b1, 1'b1, a, $urandom);
        8:          op(d, 1'b1, 1'b0, oor, 32'h0);
        default:    op(d, 1'b0, 1'b1, oor, $urandom);
      endcase
      idle(d, $urandom_range(0, 2));
    end

    idle(0, 0);
    idle(1, 5);
    chk("u0_queue_drained", 32'(exp_q0.size()), 32'h0, 32'h0);
    chk("u1_queue_drained", 32'(exp_q1.size()), 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
